pokey_audio_mixer: RTL and testbench



---
 rtl/pokey_audio_mixer.sv | 103 ++++++++++
 tb/tb_pokey_audio_mixer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pokey_audio_mixer.sv
// rtl/pokey_audio_mixer.sv - POKEY mixer: channel sync, volume summer, 1-bit DAC with period strobe
// Define POKEY_MIXER_DELTASIGMA_EN to swap the contiguous PWM comparator for a first-order delta-sigma modulator.
module pokey_audio_mixer #(
   parameter int PERIOD = 60
) (
   input  logic       clk,
   input  logic       init_L,
   input  logic       audio1,
   input  logic       audio2,
   input  logic       audio3,
   input  logic       audio4,
   input  logic [3:0] vol1,
   input  logic [3:0] vol2,
   input  logic [3:0] vol3,
   input  logic [3:0] vol4,
   input  logic       mute,
   output logic [5:0] level,
   output logic       pwm_out,
   output logic       strobe
);
   localparam int CW = ($clog2(PERIOD + 1) > 6) ? $clog2(PERIOD + 1) : 6;
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

   logic [3:0]    sync1, sync2;
   logic [3:0]    vol1_q, vol2_q, vol3_q, vol4_q;
   logic [5:0]    sum;
   logic [CW-1:0] cnt, hold, cnt_next, hold_next;
   logic          wrap;

   always_ff @(posedge clk or negedge init_L) begin
      if (!init_L) begin
         sync1  <= '0;
         sync2  <= '0;
         vol1_q <= '0;
         vol2_q <= '0;
         vol3_q <= '0;
         vol4_q <= '0;
         level  <= '0;
      end else begin
         sync1  <= {audio4, audio3, audio2, audio1};
         sync2  <= sync1;
         vol1_q <= vol1;
         vol2_q <= vol2;
         vol3_q <= vol3;
         vol4_q <= vol4;
         level  <= mute ? 6'd0 : sum;
      end
   end

   // Four 4-bit terms peak at 60, so a 6-bit sum cannot overflow.
   always_comb begin
      sum = 6'd0;
      if (sync2[0]) sum = sum + {2'b00, vol1_q};
      if (sync2[1]) sum = sum + {2'b00, vol2_q};
      if (sync2[2]) sum = sum + {2'b00, vol3_q};
      if (sync2[3]) sum = sum + {2'b00, vol4_q};
   end

   assign wrap      = (cnt == LAST);
   assign cnt_next  = wrap ? '0 : cnt + CW'(1);
   assign hold_next = wrap ? CW'(level) : hold;

   always_ff @(posedge clk or negedge init_L) begin
      if (!init_L) begin
         cnt    <= LAST;
         hold   <= '0;
         strobe <= 1'b0;
      end else begin
         cnt    <= cnt_next;
         hold   <= hold_next;
         strobe <= (cnt_next == '0);
      end
   end

`ifdef POKEY_MIXER_DELTASIGMA_EN
   logic [6:0]    acc;
   logic [7:0]    t;
   logic [CW-1:0] hold_c;

   // Clamp keeps the accumulator below PERIOD so ones-per-period equals the sample.
   assign hold_c = (hold_next >= CW'(PERIOD)) ? CW'(PERIOD) : hold_next;
   assign t      = {1'b0, acc} + 8'(hold_c);

   always_ff @(posedge clk or negedge init_L) begin
      if (!init_L) begin
         acc     <= '0;
         pwm_out <= 1'b0;
      end else if (t >= 8'(PERIOD)) begin
         acc     <= 7'(t - 8'(PERIOD));
         pwm_out <= 1'b1;
      end else begin
         acc     <= t[6:0];
         pwm_out <= 1'b0;
      end
   end
`else
   always_ff @(posedge clk or negedge init_L) begin
      if (!init_L) pwm_out <= 1'b0;
      else         pwm_out <= (cnt_next < hold_next);
   end
`endif

endmodule

// File: tb/tb_pokey_audio_mixer.sv
// tb/tb_pokey_audio_mixer.sv - directed self-checking bench for pokey_audio_mixer
module tb_pokey_audio_mixer;
   logic       clk = 1'b0;
   logic       init_L;
   logic       audio1, audio2, audio3, audio4;
   logic [3:0] vol1, vol2, vol3, vol4;
   logic       mute;
   logic [5:0] level;
   logic       pwm_out;
   logic       strobe;

   int n_assert = 0;
   int n_fail   = 0;

   pokey_audio_mixer #(.PERIOD(60)) dut (
      .clk    (clk),
      .init_L (init_L),
      .audio1 (audio1),
      .audio2 (audio2),
      .audio3 (audio3),
      .audio4 (audio4),
      .vol1   (vol1),
      .vol2   (vol2),
      .vol3   (vol3),
      .vol4   (vol4),
      .mute   (mute),
      .level  (level),
      .pwm_out(pwm_out),
      .strobe (strobe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_strobe(input string tag);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (strobe !== 1'b1 && k < 200);
      chk({tag, "_wait"}, strobe, 1);
   endtask

   // Called in a strobe cycle; samples one full period and ends in the next strobe cycle.
   // action 1: add channel 2 at vol 11 at index act_idx; action 2: assert mute at act_idx.
   task automatic measure(input string tag, input int exp_ones, input int action, input int act_idx);
      int   ones, trans, extra;
      logic prev, contig, seen_low;
      ones = 0; trans = 0; extra = 0;
      contig = 1'b1; seen_low = 1'b0; prev = pwm_out;
      for (int i = 0; i < 60; i++) begin
         if (i > 0) begin
            @(negedge clk);
            if (strobe !== 1'b0) extra++;
            if (pwm_out !== prev) trans++;
         end
         if (pwm_out === 1'b1) begin
            ones++;
            if (seen_low) contig = 1'b0;
         end else begin
            seen_low = 1'b1;
         end
         prev = pwm_out;
         if (action == 2 && i == act_idx + 1) chk({tag, "_mute_level"}, level, 0);
         if (action == 1 && i == act_idx) begin audio2 = 1'b1; vol2 = 4'd11; end
         if (action == 2 && i == act_idx) mute = 1'b1;
      end
      chk({tag, "_ones"}, ones, exp_ones);
      chk({tag, "_extra_strobes"}, extra, 0);
`ifdef POKEY_MIXER_DELTASIGMA_EN
      if (exp_ones == 30) chk({tag, "_alternation"}, trans, 59);
`else
      chk({tag, "_contiguous"}, contig, 1);
`endif
      @(negedge clk);
      chk({tag, "_next_strobe"}, strobe, 1);
   endtask

   task automatic wait_level(input string tag, input int exp);
      repeat (3) @(negedge clk);
      chk(tag, level, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      init_L = 1'b0; mute = 1'b0;
      audio1 = 1'b0; audio2 = 1'b0; audio3 = 1'b0; audio4 = 1'b0;
      vol1 = 4'd0; vol2 = 4'd0; vol3 = 4'd0; vol4 = 4'd0;

      #32;
      chk("rst_level", level, 0);
      chk("rst_pwm", pwm_out, 0);
      chk("rst_strobe", strobe, 0);

      @(negedge clk);
      init_L = 1'b1;
      @(negedge clk);
      chk("first_strobe", strobe, 1);
      measure("idle", 0, 0, 0);

      audio1 = 1'b1; vol1 = 4'd9;
      @(negedge clk); chk("lat_a1", level, 0);
      @(negedge clk); chk("lat_a2", level, 0);
      @(negedge clk); chk("lat_a3", level, 9);
      wait_strobe("single");
      measure("single", 9, 0, 0);

      audio2 = 1'b1; audio3 = 1'b1; audio4 = 1'b1;
      wait_level("zero_vol_chans", 9);
      vol1 = 4'd15; vol2 = 4'd15; vol3 = 4'd15; vol4 = 4'd15;
      @(negedge clk); chk("lat_v1", level, 9);
      @(negedge clk); chk("lat_v2", level, 60);
      wait_strobe("full");
      measure("full", 60, 0, 0);

      audio1 = 1'b0; audio2 = 1'b0; audio3 = 1'b0; audio4 = 1'b0;
      wait_level("all_off_level", 0);
      wait_strobe("all_off");
      measure("all_off", 0, 0, 0);

      audio1 = 1'b1; vol1 = 4'd9; vol2 = 4'd0;
      wait_level("mid_level", 9);
      wait_strobe("mid");
      measure("mid_a", 9, 1, 30);
      measure("mid_b", 20, 0, 0);

      audio3 = 1'b1; vol1 = 4'd15; vol2 = 4'd15; vol3 = 4'd15;
      wait_level("mute_pre_level", 45);
      wait_strobe("mute");
      measure("mute_a", 45, 2, 10);
      measure("mute_b", 0, 0, 0);
      mute = 1'b0;
      wait_strobe("unmute");
      measure("unmute", 45, 0, 0);

      repeat (5) @(negedge clk);
      chk("pre_rst_pwm", pwm_out, 1);
      #2 init_L = 1'b0;
      #1;
      chk("mid_rst_pwm", pwm_out, 0);
      chk("mid_rst_level", level, 0);
      chk("mid_rst_strobe", strobe, 0);
      @(negedge clk);
      init_L = 1'b1;
      @(negedge clk);
      chk("restart_strobe", strobe, 1);
      measure("post_rst_a", 0, 0, 0);
      measure("post_rst_b", 45, 0, 0);

      audio3 = 1'b0;
      wait_level("half_level", 30);
      wait_strobe("half");
      measure("half", 30, 0, 0);

      audio2 = 1'b0; vol1 = 4'd1;
      wait_level("one_level", 1);
      wait_strobe("one");
      measure("one", 1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
